// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive bus controller: flag-edge byte detect, byte FIFO, DATA/STATUS/CTRL regs, level irq
// Optional macro UART_RX_CTRL_WATERMARK_EN: irq on count >= watermark (0 treated as 1) or overrun.
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  input  logic [1:0]  bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  logic          flag_q,    flag_d;
  logic [AW-1:0] wptr_q,    wptr_d;
  logic [AW-1:0] rptr_q,    rptr_d;
  logic [AW:0]   count_q,   count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    ctrl_q,    ctrl_d;
  logic [31:0]   rdata_q,   rdata_d;
  logic          irq_q,     irq_d;

  logic [7:0]    mem_q [DEPTH];

  logic          push_evt;
  logic          rd_data;
  logic          pop;
  logic          push_ok;
  logic          ovr_evt;
  logic          not_empty;
  logic          full;
  logic [31:0]   status_word;

`ifdef UART_RX_CTRL_WATERMARK_EN
  logic [3:0]    wmark;
`endif

  // Only the low control byte and the overrun-clear bit of the write bus carry meaning.
  logic          unused_wdata;
  assign unused_wdata = ^bus_wdata[31:8];

  // Byte detect, FIFO bookkeeping, register access and next irq level.
  always_comb begin
    flag_d      = rx_flag;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overrun_d   = overrun_q;
    ctrl_d      = ctrl_q;
    rdata_d     = rdata_q;
    irq_d       = 1'b0;

    // A flag edge is a byte; flag_q tracks rx_flag even while disabled so re-enabling never sees a stale edge.
    push_evt    = (rx_flag ^ flag_q) & ctrl_q[0];
    rd_data     = bus_rd & (bus_addr == ADDR_DATA);
    not_empty   = (count_q != '0);
    full        = (count_q == CNT_FULL);
    pop         = rd_data & not_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push_ok     = push_evt & (~full | pop);
    ovr_evt     = push_evt & full & ~pop;

    status_word = {16'b0, 3'b0, 5'(count_q), 4'b0, irq_q, overrun_q, full, not_empty};

    if (push_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end

    if (bus_wr && (bus_addr == ADDR_CTRL)) begin
      ctrl_d = bus_wdata[7:0];
    end
    if (bus_wr && (bus_addr == ADDR_STATUS) && bus_wdata[2]) begin
      overrun_d = 1'b0;
    end
    // Set after clear so a coincident overrun is not lost.
    if (ovr_evt) begin
      overrun_d = 1'b1;
    end

    if (bus_rd) begin
      case (bus_addr)
        ADDR_DATA:   rdata_d = pop ? {24'b0, mem_q[rptr_q]} : 32'b0;
        ADDR_STATUS: rdata_d = status_word;
        ADDR_CTRL:   rdata_d = {24'b0, ctrl_q};
        default:     rdata_d = 32'b0;
      endcase
    end

`ifdef UART_RX_CTRL_WATERMARK_EN
    wmark = (ctrl_d[7:4] == 4'd0) ? 4'd1 : ctrl_d[7:4];
    irq_d = ctrl_d[1] & ((32'(count_d) >= 32'(wmark)) | overrun_d);
`else
    irq_d = ctrl_d[1] & (count_d != '0);
`endif
  end

  // Control and status state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ctrl_q    <= 8'h00;
      rdata_q   <= 32'b0;
      irq_q     <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  // Byte storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= rx_data;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl: register vector table, FIFO scoreboard, corner sequences
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic [1:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq       (irq)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]  m_fifo[$];
  logic        m_ovr;
  logic [7:0]  m_ctrl;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[6];

  function automatic logic m_irq();
`ifdef UART_RX_CTRL_WATERMARK_EN
    int wm;
    wm = (m_ctrl[7:4] == 4'd0) ? 1 : int'(m_ctrl[7:4]);
    return m_ctrl[1] & ((m_fifo.size() >= wm) | m_ovr);
`else
    return m_ctrl[1] & (m_fifo.size() != 0);
`endif
  endfunction

  function automatic logic [31:0] m_status();
    int c;
    c = m_fifo.size();
    return {16'b0, 3'b0, 5'(c), 4'b0, m_irq(), m_ovr, (c == 16), (c != 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_rd(input logic [1:0] a, output logic [31:0] e);
    case (a)
      2'd0: begin
        if (m_fifo.size() > 0) e = {24'b0, m_fifo.pop_front()};
        else e = 32'b0;
      end
      2'd1: e = m_status();
      2'd2: e = {24'b0, m_ctrl};
      default: e = 32'b0;
    endcase
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_ctrl[0]) begin
      if (m_fifo.size() < 16) m_fifo.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic rd_expect(input logic [1:0] a, input logic [31:0] e, input string name);
    bus_addr = a;
    bus_rd   = 1'b1;
    exp_q.push_back(e);
    step();
    bus_rd = 1'b0;
    check(name, bus_rdata, exp_q.pop_front());
  endtask

  task automatic bus_read(input logic [1:0] a, input string name);
    logic [31:0] e;
    model_rd(a, e);
    rd_expect(a, e, name);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wr    = 1'b1;
    bus_wdata = d;
    if (a == 2'd2) m_ctrl = d[7:0];
    if (a == 2'd1 && d[2]) m_ovr = 1'b0;
    step();
    bus_wr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = ~rx_flag;
    model_push(b);
    step();
  endtask

  task automatic push_read(input logic [7:0] b, input string name);
    logic [31:0] e;
    rx_data  = b;
    rx_flag  = ~rx_flag;
    bus_addr = 2'd0;
    bus_rd   = 1'b1;
    model_rd(2'd0, e);
    model_push(b);
    exp_q.push_back(e);
    step();
    bus_rd = 1'b0;
    check(name, bus_rdata, exp_q.pop_front());
  endtask

  initial begin
    vecs[0] = '{2'd2, 32'hFFFF_FF5A, 32'h0000_005A, "ctrl_5a"};
    vecs[1] = '{2'd2, 32'h0000_00F0, 32'h0000_00F0, "ctrl_f0"};
    vecs[2] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, "rsvd_rd"};
    vecs[3] = '{2'd0, 32'h0000_00AB, 32'h0000_0000, "data_wr_ignored"};
    vecs[4] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000, "status_wr"};
    vecs[5] = '{2'd2, 32'h0000_0000, 32'h0000_0000, "ctrl_clr"};

    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_flag   = 1'b0;
    bus_addr  = 2'd0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = 32'b0;
    m_ovr     = 1'b0;
    m_ctrl    = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus_rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    step();
    rd_expect(2'd1, 32'h0, "reset_status");
    rd_expect(2'd2, 32'h0, "reset_ctrl");

    // register table
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      rd_expect(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
    end

    // test 1: single byte round trip
    bus_write(2'd2, 32'h3);
    push_byte(8'hA5);
    rd_expect(2'd1, 32'h0000_0109, "t1_status");
    check("t1_irq_hi", {31'b0, irq}, 32'h1);
    void'(m_fifo.pop_front());
    rd_expect(2'd0, 32'h0000_00A5, "t1_data");
    check("t1_irq_lo", {31'b0, irq}, 32'h0);
    rd_expect(2'd1, 32'h0, "t1_status_empty");

    // test 2: toggles while disabled produce no phantom bytes
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i));
    bus_write(2'd2, 32'h3);
    step();
    rd_expect(2'd1, 32'h0, "t2_status_none");
    push_byte(8'h5C);
    rd_expect(2'd1, 32'h0000_0109, "t2_status_one");
    bus_read(2'd0, "t2_data");

    // test 3: overrun on 17th byte
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    rd_expect(2'd1, 32'h0000_100F, "t3_status_full_ovr");
    for (int i = 0; i < 16; i++) bus_read(2'd0, "t3_drain");
    bus_read(2'd1, "t3_status_ovr_only");
    bus_write(2'd1, 32'h4);
    rd_expect(2'd1, 32'h0, "t3_status_cleared");

    // test 4: full FIFO with simultaneous push/pop, pointer wrap over 40 bytes
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    for (int i = 0; i < 24; i++) push_read(8'h40 + 8'(i), "t4_pushpop");
    rd_expect(2'd1, 32'h0000_100B, "t4_status_full_no_ovr");
    for (int i = 0; i < 16; i++) bus_read(2'd0, "t4_drain");
    push_read(8'h77, "t4_pushpop_empty");
    rd_expect(2'd1, 32'h0000_0109, "t4_status_one");
    bus_read(2'd0, "t4_last");

    // test 5: empty read, then asynchronous reset mid-stream
    rd_expect(2'd0, 32'h0, "t5_empty_data");
    rd_expect(2'd1, 32'h0, "t5_empty_status");
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    rd_expect(2'd1, 32'h0000_0509, "t5_status_five");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_rdata", bus_rdata, 32'h0);
    check("t5_async_irq", {31'b0, irq}, 32'h0);
    m_fifo.delete();
    m_ovr  = 1'b0;
    m_ctrl = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    step();
    rd_expect(2'd1, 32'h0, "t5_post_status");
    rd_expect(2'd2, 32'h0, "t5_post_ctrl");
    rd_expect(2'd0, 32'h0, "t5_post_data");

    // test 6: watermark 4
    bus_write(2'd2, 32'h43);
    for (int n = 1; n <= 5; n++) begin
      logic exp_irq;
      push_byte(8'h80 + 8'(n));
`ifdef UART_RX_CTRL_WATERMARK_EN
      exp_irq = (n >= 4);
`else
      exp_irq = 1'b1;
`endif
      check($sformatf("t6_irq_after_%0d", n), {31'b0, irq}, {31'b0, exp_irq});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Bus-side controller for the UART receiver datapath. It detects each completed byte from the receiver's toggle-style completion flag, buffers bytes in a small FIFO, and exposes DATA/STATUS/CTRL registers to the CPU pipeline's peripheral bus. It drives a level interrupt to the CPU. It also gates reception through a software-controlled enable.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2
AW, 4, log2(DEPTH); pointer width; occupancy counter is AW+1 bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from receiver; stable from the flag toggle until the next toggle
rx_flag  input  1  receiver completion flag; inverts once per received byte; synchronous to clk
bus_addr  input  2  register select (word address): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
bus_rd  input  1  read strobe, one cycle per access
bus_wr  input  1  write strobe, one cycle per access
bus_wdata  input  32  write data
bus_rdata  output  32  read data, registered
irq  output  1  level interrupt to CPU

Behaviour:
- Reset: FIFO empty, read/write pointers 0, count 0, overrun 0, CTRL = 0 (rx_en 0, irq_en 0), bus_rdata 0, irq 0, flag_q 0.
- Byte detect: flag_q <= rx_flag every cycle, regardless of rx_en. push_evt = (rx_flag ^ flag_q) & rx_en.
  - Disabling and re-enabling reception never generates a phantom push.
  - The first cycle after reset treats flag_q = 0. If rx_flag = 1 at reset release, that is one event.
- Push: on push_evt with count < DEPTH, mem[wptr] <= rx_data, wptr+1 (wraps mod DEPTH), count+1.
- Pop: bus_rd with bus_addr = 0 and count > 0.
  - bus_rdata <= {24'b0, mem[rptr]}; rptr+1 (wraps); count-1.
  - Pop when empty: bus_rdata <= 0; no pointer or count change.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the pop frees the slot and the push is accepted; no overrun.
  - When empty, the pop returns 0 and the push is stored, giving count 1.
- Overrun: push_evt with count = DEPTH and no same-cycle pop drops the byte and sets the sticky overrun bit.
- STATUS read (addr 1): bus_rdata <= {16'b0, 3'b0, count[AW:0] zero-extended into bits 12:8, 4'b0, irq, overrun, full, not_empty}. Bits: bit0 not_empty, bit1 full (count = DEPTH), bit2 overrun, bit3 irq.
- STATUS write (addr 1): bus_wdata[2] = 1 clears overrun. If an overrun event occurs in the same cycle, set wins.
- CTRL (addr 2): R/W. bit0 rx_en, bit1 irq_en, bits 7:4 watermark (used only with the optional feature). Read returns {24'b0, ctrl[7:0]}.
- DATA write and all addr 3 accesses: ignored; reads return 0.
- Read latency: bus_rdata updates the cycle after bus_rd is sampled. It holds its value when there is no read.
- Simultaneous bus_rd and bus_wr: the write is performed and the read is also performed.
- irq, registered: irq <= irq_en & not_empty, computed from the post-update count. It drops the cycle after the pop that empties the FIFO.

Optional Feature:
UART_RX_CTRL_WATERMARK_EN
- Defined: irq <= irq_en & (count >= max(watermark,1) | overrun). Watermark 0 is treated as 1.
- Undefined: CTRL bits 7:4 are still R/W storage but have no effect. irq follows not_empty only.

Test Plan:
1. Reset, write CTRL=0x3, toggle rx_flag with rx_data=0xA5 -> STATUS reads 0x0000_0109, irq=1. DATA read returns 0x0000_00A5. Next cycle irq=0, STATUS=0x0000_0000.
2. rx_en=0, toggle rx_flag 3 times, then set rx_en=1 -> count stays 0. Next single toggle -> count 1, no extra bytes.
3. Push 17 bytes 0x00..0x10 with DEPTH=16 -> STATUS full=1, overrun=1. Reads return 0x00..0x0F in order; 0x10 is lost. Write STATUS 0x4 -> overrun 0.
4. Full FIFO with toggle and DATA read in the same cycle -> read returns oldest byte, new byte accepted, count stays 16, overrun stays 0. Pointer wrap verified over 40 bytes in total.
5. DATA read on empty FIFO -> bus_rdata 0, count 0. Assert rst_n low mid-stream with 5 bytes queued -> all registers return to reset values immediately.
6. With UART_RX_CTRL_WATERMARK_EN and CTRL=0x43 -> irq stays 0 for 3 bytes and rises after the 4th. Without the macro, irq rises after the 1st byte.
